// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: merges ALU results and load returns into one register write stream.
// Optional WB_R0_FILTER_EN: rd=0 writes are accepted but never issued or queued.
module regfile_wb_ctrl #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [31:0]              alu_data,
    output logic                     alu_ready,
    input  logic                     ld_valid,
    input  logic [4:0]               ld_rd,
    input  logic [31:0]              ld_data,
    output logic                     ld_ready,
    output logic [4:0]               dec_s,
    output logic                     dec_en_n,
    output logic [31:0]              wr_data,
    output logic [$clog2(DEPTH):0]   fifo_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);

    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [AW:0]      cnt;
    logic [DEPTH-1:0] q_vld;
    logic [4:0]       q_rd   [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [SW-1:0]    starve_cnt;
    logic             starve;

    logic             nonempty;
    logic             alu_fire;
    logic             alu_live;
    logic             ld_live;
    logic             alu_issue;
    logic             ld_fire;
    logic             ld_hit;
    logic             push;
    logic             pop;
    logic [DEPTH-1:0] sq_mask;
    logic [AW:0]      cnt_nxt;

`ifdef WB_R0_FILTER_EN
    assign alu_live = (alu_rd != 5'd0);
    assign ld_live  = (ld_rd != 5'd0);
`else
    assign alu_live = 1'b1;
    assign ld_live  = 1'b1;
`endif

    assign nonempty  = (cnt != '0);
    // ALU is held off only for the single forced load issue
    assign alu_ready = !(starve && nonempty);
    assign ld_ready  = (cnt < FULL);
    assign fifo_cnt  = cnt;

    assign alu_fire  = alu_valid & alu_ready;
    assign alu_issue = alu_fire & alu_live;
    // The FIFO drains whenever the ALU does not take the slot
    assign pop       = !alu_fire & nonempty;
    assign ld_fire   = ld_valid & ld_ready;
    // A load racing a younger ALU write to the same rd is dropped
    assign ld_hit    = alu_issue & (ld_rd == alu_rd);
    assign push      = ld_fire & ld_live & !ld_hit;

    // Entries overwritten by an issuing ALU write lose their valid bit
    always_comb begin
        sq_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sq_mask[i] = alu_issue & q_vld[i] & (q_rd[i] == alu_rd);
        end
    end

    // Next occupancy from push/pop
    always_comb begin
        cnt_nxt = cnt;
        unique case ({push, pop})
            2'b10:   cnt_nxt = cnt + 1'b1;
            2'b01:   cnt_nxt = cnt - 1'b1;
            default: cnt_nxt = cnt;
        endcase
    end

    // Load FIFO storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
            q_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_rd[i]   <= '0;
                q_data[i] <= '0;
            end
        end else begin
            q_vld <= q_vld & ~sq_mask;
            if (push) begin
                q_vld[tail]  <= 1'b1;
                q_rd[tail]   <= ld_rd;
                q_data[tail] <= ld_data;
                tail         <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            cnt <= cnt_nxt;
        end
    end

    // Starvation guard: count stalled cycles of a non-empty FIFO
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            starve     <= 1'b0;
        end else if (!nonempty || pop) begin
            starve_cnt <= '0;
            starve     <= 1'b0;
        end else if (!starve) begin
            starve_cnt <= starve_cnt + 1'b1;
            if (starve_cnt == STARVE_LAST) begin
                starve <= 1'b1;
            end
        end
    end

    // Registered decoder drive: at most one write per cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dec_s    <= '0;
            dec_en_n <= 1'b1;
            wr_data  <= '0;
        end else begin
            dec_en_n <= 1'b1;
            if (alu_issue) begin
                dec_s    <= alu_rd;
                dec_en_n <= 1'b0;
                wr_data  <= alu_data;
            end else if (pop && q_vld[head]) begin
                dec_s    <= q_rd[head];
                dec_en_n <= 1'b0;
                wr_data  <= q_data[head];
            end
        end
    end

endmodule
